// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with valid/ready output and sticky overrun.
// Optional even-parity frame bit enabled by defining SIPO_PARITY_EN.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] p,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             busy,
  output logic             overrun
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    count;
  logic             data_bit;
  logic             complete;
  logic             load;

  always_comb begin
    sr_shifted = sr;
    if (MSB_FIRST) sr_shifted = {sr[WIDTH-2:0], serial_in};
    else           sr_shifted = {serial_in, sr[WIDTH-1:1]};

    complete = in_valid && (count == LAST);
`ifdef SIPO_PARITY_EN
    // The final frame bit is parity only; the data word is already complete in sr.
    data_bit = in_valid && (count != LAST);
    word     = sr;
`else
    data_bit = in_valid;
    word     = sr_shifted;
`endif
    load = complete && (!p_valid || p_ready);
  end

  assign busy = (count != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr      <= '0;
      count   <= '0;
      p       <= '0;
      p_valid <= 1'b0;
      overrun <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (data_bit) sr <= sr_shifted;
      if (in_valid) count <= complete ? '0 : count + CW'(1);

      if (load) begin
        p       <= word;
        p_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
        parity_err <= (^sr) ^ serial_in;
`endif
      end else if (complete) begin
        overrun <= 1'b1;
      end else if (p_valid && p_ready) begin
        p_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomised and directed bench for sipo_deserializer: MSB-first and LSB-first
// instances share one stream and are checked against a frame-queue model.
module tb_sipo_deserializer;

  localparam int W = 4;
`ifdef SIPO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk;
  logic         rst;
  logic         serial_in;
  logic         in_valid;
  logic         p_ready;
  logic [W-1:0] p_msb, p_lsb;
  logic         pv_msb, pv_lsb, busy_msb, busy_lsb, ovr_msb, ovr_lsb;
`ifdef SIPO_PARITY_EN
  logic         perr_msb, perr_lsb;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bit           frame_q[$];
  logic [W-1:0] exp_p_msb, exp_p_lsb;
  logic         exp_pv, exp_ovr, exp_perr;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
    .p(p_msb), .p_valid(pv_msb), .p_ready(p_ready), .busy(busy_msb),
    .overrun(ovr_msb)
`ifdef SIPO_PARITY_EN
    , .parity_err(perr_msb)
`endif
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
    .p(p_lsb), .p_valid(pv_lsb), .p_ready(p_ready), .busy(busy_lsb),
    .overrun(ovr_lsb)
`ifdef SIPO_PARITY_EN
    , .parity_err(perr_lsb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: collect the bits of the current frame, place them by bit order on completion.
  function automatic void model_step();
    logic [W-1:0] wm, wl;
    bit par;
    if (!rst) begin
      frame_q.delete();
      exp_p_msb = '0;
      exp_p_lsb = '0;
      exp_pv    = 1'b0;
      exp_ovr   = 1'b0;
      exp_perr  = 1'b0;
      return;
    end
    if (in_valid) frame_q.push_back(serial_in);
    if (in_valid && frame_q.size() == FRAME) begin
      wm  = '0;
      wl  = '0;
      par = 1'b0;
      for (int i = 0; i < W; i++) begin
        wm[W-1-i] = frame_q[i];
        wl[i]     = frame_q[i];
      end
      foreach (frame_q[i]) par ^= frame_q[i];
      if (!exp_pv || p_ready) begin
        exp_p_msb = wm;
        exp_p_lsb = wl;
        exp_pv    = 1'b1;
        exp_perr  = par;
      end else begin
        exp_ovr = 1'b1;
      end
      frame_q.delete();
    end else if (exp_pv && p_ready) begin
      exp_pv = 1'b0;
    end
  endfunction

  task automatic compare_all();
    check("p_msb",    32'(p_msb),    32'(exp_p_msb));
    check("p_lsb",    32'(p_lsb),    32'(exp_p_lsb));
    check("pv_msb",   32'(pv_msb),   32'(exp_pv));
    check("pv_lsb",   32'(pv_lsb),   32'(exp_pv));
    check("busy_msb", 32'(busy_msb), 32'(frame_q.size() != 0));
    check("busy_lsb", 32'(busy_lsb), 32'(frame_q.size() != 0));
    check("ovr_msb",  32'(ovr_msb),  32'(exp_ovr));
    check("ovr_lsb",  32'(ovr_lsb),  32'(exp_ovr));
`ifdef SIPO_PARITY_EN
    check("perr_msb", 32'(perr_msb), 32'(exp_perr));
    check("perr_lsb", 32'(perr_lsb), 32'(exp_perr));
`endif
  endtask

  task automatic cycle(input logic r, input logic v, input logic s, input logic rd);
    rst       = r;
    in_valid  = v;
    serial_in = s;
    p_ready   = rd;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Sends bits[n-1] first; p_ready is rd_mid for all but the last bit.
  task automatic send_bits(input logic [7:0] bits, input int n, input logic rd_mid,
                           input logic rd_last);
    for (int i = n - 1; i >= 0; i--)
      cycle(1'b1, 1'b1, bits[i], (i == 0) ? rd_last : rd_mid);
  endtask

  initial begin
    int thr;
    rst = 1'b0; in_valid = 1'b0; serial_in = 1'b0; p_ready = 1'b0;
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_p",   32'(p_msb),   32'h0);
    check("rst_pv",  32'(pv_msb),  32'h0);
    check("rst_ovr", 32'(ovr_msb), 32'h0);

`ifndef SIPO_PARITY_EN
    send_bits(8'b1001, 4, 1'b1, 1'b1);
    check("tp1_p",  32'(p_msb),  32'b1001);
    check("tp1_pv", 32'(pv_msb), 32'h1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("tp1_consumed", 32'(pv_msb), 32'h0);

    send_bits(8'b1100, 4, 1'b1, 1'b1);
    check("tp2_lsb", 32'(p_lsb), 32'b0011);

    send_bits(8'b10, 2, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1);
    check("tp3_busy_gap", 32'(busy_msb), 32'h1);
    send_bits(8'b11, 2, 1'b1, 1'b1);
    check("tp3_p", 32'(p_msb), 32'b1011);

    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    send_bits(8'b1010, 4, 1'b0, 1'b0);
    send_bits(8'b0110, 4, 1'b0, 1'b0);
    check("tp4_p",   32'(p_msb),   32'b1010);
    check("tp4_pv",  32'(pv_msb),  32'h1);
    check("tp4_ovr", 32'(ovr_msb), 32'h1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("tp4_pv_drop", 32'(pv_msb),  32'h0);
    check("tp4_sticky",  32'(ovr_msb), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("tp4_ovr_clr", 32'(ovr_msb), 32'h0);

    send_bits(8'b11, 2, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("tp5_busy", 32'(busy_msb), 32'h0);
    send_bits(8'b0101, 4, 1'b1, 1'b1);
    check("tp5_p", 32'(p_msb), 32'b0101);

    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    send_bits(8'b0011, 4, 1'b0, 1'b0);
    send_bits(8'b1110, 4, 1'b0, 1'b1);
    check("tp6_p",   32'(p_msb),   32'b1110);
    check("tp6_pv",  32'(pv_msb),  32'h1);
    check("tp6_ovr", 32'(ovr_msb), 32'h0);
`else
    send_bits(8'b10010, 5, 1'b1, 1'b1);
    check("par_p",    32'(p_msb),    32'b1001);
    check("par_ok",   32'(perr_msb), 32'h0);
    send_bits(8'b10011, 5, 1'b1, 1'b1);
    check("par_err",  32'(perr_msb), 32'h1);
    check("par_pv",   32'(pv_msb),   32'h1);
`endif

    thr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) thr = (c / 500 % 3 == 0) ? 10 : ((c / 500 % 3 == 1) ? 90 : 50);
      cycle(logic'($urandom_range(0, 199) != 0), logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 99) < thr));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
